// File: rtl/pcs_block_lock_if.sv
// pcs_block_lock_if
//   Bundles the per-lane sync-header stream from the gearbox and the
//   lock/slip status returned by the block-lock controller.
//
//   valid_i    [LANE_N]         header valid, bit x qualifies head_i lane x
//   head_i     [LANE_N*HEAD_W]  per-lane 2-bit sync header
//   slip_o     [LANE_N]         one-cycle gearbox bit-slip request
//   lock_o     [LANE_N]         per-lane block_lock
//   lock_all_o                  AND of all lock_o bits
//
//   master: gearbox / deskew side (drives headers, receives status)
//   slave : block-lock controller
interface pcs_block_lock_if #(
    parameter int LANE_N = 4,
    parameter int HEAD_W = 2
);
    logic [LANE_N-1:0]        valid_i;
    logic [LANE_N*HEAD_W-1:0] head_i;
    logic [LANE_N-1:0]        slip_o;
    logic [LANE_N-1:0]        lock_o;
    logic                     lock_all_o;

    modport master (
        output valid_i,
        output head_i,
        input  slip_o,
        input  lock_o,
        input  lock_all_o
    );

    modport slave (
        input  valid_i,
        input  head_i,
        output slip_o,
        output lock_o,
        output lock_all_o
    );
endinterface

// File: rtl/pcs_block_lock.sv
// pcs_block_lock
//   Per-lane 66b block-lock controller for the 10G/40GBASE-R receive path.
//   Each lane watches its sync headers, requests a gearbox bit-slip on a bad
//   header while searching, declares lock after SH_CNT_MAX consecutive good
//   headers, and drops lock when SH_INVLD_MAX bad headers land in one window.
//   Lanes are independent; only lock_all_o combines them.
//
//   clk     PCS clock
//   nreset  asynchronous active-low reset
//   bus     pcs_block_lock_if.slave (valid_i, head_i, slip_o, lock_o, lock_all_o)
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_SEARCH   | counting consecutive good headers toward lock
// ST_LOCKED   | block_lock asserted, counting bad headers per window
// ST_SLIP     | slip issued on entry, headers ignored while gearbox settles
module pcs_block_lock #(
    parameter int LANE_N       = 4,
    parameter int HEAD_W       = 2,
    parameter int SH_CNT_MAX   = 64,
    parameter int SH_INVLD_MAX = 16,
    parameter int SLIP_WAIT_N  = 4
) (
    input  logic              clk,
    input  logic              nreset,
    pcs_block_lock_if.slave   bus
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_SLIP   = 2'd2;

    localparam logic [6:0]        SH_MAX    = 7'(SH_CNT_MAX);
    localparam logic [4:0]        INVLD_MAX = 5'(SH_INVLD_MAX);
    // Wait timer is a down-counter; loading N-1 gives exactly N cycles in SLIP.
    localparam logic [3:0]        WAIT_LOAD = 4'(SLIP_WAIT_N - 1);
    localparam logic [HEAD_W-1:0] HEAD_01   = HEAD_W'(1);
    localparam logic [HEAD_W-1:0] HEAD_10   = HEAD_W'(2);

    logic [LANE_N-1:0] slip_v;
    logic [LANE_N-1:0] lock_v;

    for (genvar g = 0; g < LANE_N; g++) begin : g_lane
        logic [1:0]        state_q, state_d;
        logic [6:0]        sh_cnt_q, sh_cnt_d;
        logic [4:0]        invld_cnt_q, invld_cnt_d;
        logic [3:0]        wait_cnt_q, wait_cnt_d;
        logic              slip_q, slip_d;
        logic              lock_q, lock_d;
        logic [HEAD_W-1:0] head;
        logic              hdr_ok;
        logic              hdr_vld;
        logic [6:0]        sh_inc;
        logic [4:0]        invld_inc;

        assign head      = bus.head_i[g*HEAD_W +: HEAD_W];
        assign hdr_vld   = bus.valid_i[g];
        assign hdr_ok    = (head == HEAD_01) || (head == HEAD_10);
        assign sh_inc    = sh_cnt_q + 7'd1;
        assign invld_inc = invld_cnt_q + {4'd0, ~hdr_ok};

        always_comb begin
            state_d     = state_q;
            sh_cnt_d    = sh_cnt_q;
            invld_cnt_d = invld_cnt_q;
            wait_cnt_d  = wait_cnt_q;
            slip_d      = 1'b0;

            case (state_q)
                ST_SEARCH: begin
                    if (hdr_vld) begin
                        if (!hdr_ok) begin
                            state_d     = ST_SLIP;
                            slip_d      = 1'b1;
                            sh_cnt_d    = '0;
                            invld_cnt_d = '0;
                            wait_cnt_d  = WAIT_LOAD;
                        end else if (sh_inc == SH_MAX) begin
                            state_d  = ST_LOCKED;
                            sh_cnt_d = '0;
                        end else begin
                            sh_cnt_d = sh_inc;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (hdr_vld) begin
                        // Loss of lock is tested first so it wins over the
                        // window-end clear on the same header.
                        if (!hdr_ok && (invld_inc == INVLD_MAX)) begin
                            state_d     = ST_SLIP;
                            slip_d      = 1'b1;
                            sh_cnt_d    = '0;
                            invld_cnt_d = '0;
                            wait_cnt_d  = WAIT_LOAD;
                        end else if (sh_inc == SH_MAX) begin
                            sh_cnt_d    = '0;
                            invld_cnt_d = '0;
                        end else begin
                            sh_cnt_d    = sh_inc;
                            invld_cnt_d = invld_inc;
                        end
                    end
                end
                ST_SLIP: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_d     = ST_SEARCH;
                        sh_cnt_d    = '0;
                        invld_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d     = ST_SEARCH;
                    sh_cnt_d    = '0;
                    invld_cnt_d = '0;
                    wait_cnt_d  = '0;
                end
            endcase
        end

        assign lock_d = (state_d == ST_LOCKED);

        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                state_q     <= ST_SEARCH;
                sh_cnt_q    <= '0;
                invld_cnt_q <= '0;
                wait_cnt_q  <= '0;
                slip_q      <= 1'b0;
                lock_q      <= 1'b0;
            end else begin
                state_q     <= state_d;
                sh_cnt_q    <= sh_cnt_d;
                invld_cnt_q <= invld_cnt_d;
                wait_cnt_q  <= wait_cnt_d;
                slip_q      <= slip_d;
                lock_q      <= lock_d;
            end
        end

        assign slip_v[g] = slip_q;
        assign lock_v[g] = lock_q;
    end

    assign bus.slip_o     = slip_v;
    assign bus.lock_o     = lock_v;
    assign bus.lock_all_o = &lock_v;

endmodule

// File: tb/tb_pcs_block_lock.sv
// tb_pcs_block_lock
//   Randomized and directed stimulus for pcs_block_lock, checked every cycle
//   against a timestamp-based behavioural model of per-lane block lock.
module tb_pcs_block_lock;

    localparam int LANE_N       = 4;
    localparam int HEAD_W       = 2;
    localparam int SH_CNT_MAX   = 64;
    localparam int SH_INVLD_MAX = 16;
    localparam int SLIP_WAIT_N  = 4;

    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    pcs_block_lock_if #(.LANE_N(LANE_N), .HEAD_W(HEAD_W)) bus();

    pcs_block_lock #(
        .LANE_N      (LANE_N),
        .HEAD_W      (HEAD_W),
        .SH_CNT_MAX  (SH_CNT_MAX),
        .SH_INVLD_MAX(SH_INVLD_MAX),
        .SLIP_WAIT_N (SLIP_WAIT_N)
    ) dut (
        .clk   (clk),
        .nreset(nreset),
        .bus   (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Model: lock flag, good-header run length, window header/bad counts,
    // and the cycle index at which a slipping lane resumes looking at headers.
    bit                m_locked [LANE_N];
    int                m_run    [LANE_N];
    int                m_win    [LANE_N];
    int                m_bad    [LANE_N];
    int                m_resume [LANE_N];
    logic [LANE_N-1:0] m_slip;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    function automatic logic [LANE_N-1:0] m_lock_vec();
        logic [LANE_N-1:0] r;
        for (int l = 0; l < LANE_N; l++) r[l] = m_locked[l];
        return r;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < LANE_N; l++) begin
            m_locked[l] = 1'b0;
            m_run[l]    = 0;
            m_win[l]    = 0;
            m_bad[l]    = 0;
            m_resume[l] = 0;
        end
        m_slip = '0;
    endtask

    task automatic model_slip(input int l);
        m_slip[l]   = 1'b1;
        m_locked[l] = 1'b0;
        m_run[l]    = 0;
        m_win[l]    = 0;
        m_bad[l]    = 0;
        m_resume[l] = cyc + 1 + SLIP_WAIT_N;
    endtask

    // Apply the rules for the headers sampled at clock edge number cyc.
    task automatic model_cycle(input logic [LANE_N-1:0] v, input logic [LANE_N*HEAD_W-1:0] h);
        m_slip = '0;
        for (int l = 0; l < LANE_N; l++) begin
            logic [1:0] hd;
            bit bad;
            hd  = h[l*HEAD_W +: HEAD_W];
            bad = (hd == 2'b00) || (hd == 2'b11);
            if (cyc >= m_resume[l] && v[l]) begin
                if (!m_locked[l]) begin
                    if (bad) model_slip(l);
                    else begin
                        m_run[l]++;
                        if (m_run[l] == SH_CNT_MAX) begin
                            m_locked[l] = 1'b1;
                            m_run[l]    = 0;
                        end
                    end
                end else begin
                    m_win[l]++;
                    if (bad) m_bad[l]++;
                    if (m_bad[l] == SH_INVLD_MAX) model_slip(l);
                    else if (m_win[l] == SH_CNT_MAX) begin
                        m_win[l] = 0;
                        m_bad[l] = 0;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic [LANE_N-1:0] v, input logic [LANE_N*HEAD_W-1:0] h);
        @(negedge clk);
        bus.valid_i = v;
        bus.head_i  = h;
        model_cycle(v, h);
        @(posedge clk);
        #1;
        cyc++;
        chk("slip_o", 32'(bus.slip_o), 32'(m_slip));
        chk("lock_o", 32'(bus.lock_o), 32'(m_lock_vec()));
        chk("lock_all_o", 32'(bus.lock_all_o), 32'(&m_lock_vec()));
    endtask

    // Asserts reset at the current time (asynchronously) and checks outputs at once.
    task automatic do_reset();
        nreset      = 1'b0;
        bus.valid_i = '0;
        bus.head_i  = '0;
        #1;
        chk("reset slip_o", 32'(bus.slip_o), 32'h0);
        chk("reset lock_o", 32'(bus.lock_o), 32'h0);
        chk("reset lock_all_o", 32'(bus.lock_all_o), 32'h0);
        model_reset();
        @(negedge clk);
        nreset = 1'b1;
    endtask

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    endfunction

    function automatic logic [LANE_N*HEAD_W-1:0] mk(input logic [LANE_N-1:0] badmask);
        logic [LANE_N*HEAD_W-1:0] h;
        for (int l = 0; l < LANE_N; l++)
            h[l*HEAD_W +: HEAD_W] = badmask[l] ? bad_hdr() : good_hdr();
        return h;
    endfunction

    task automatic acquire();
        repeat (SH_CNT_MAX) step('1, mk('0));
    endtask

    // One window of n headers; lane l receives nbad[l] bad headers at random positions.
    task automatic window(input int n, input int nbad0, input int nbad1, input int nbad2, input int nbad3);
        logic [63:0] pos [LANE_N];
        int k [LANE_N];
        k[0] = nbad0; k[1] = nbad1; k[2] = nbad2; k[3] = nbad3;
        for (int l = 0; l < LANE_N; l++) begin
            int cnt;
            pos[l] = '0;
            cnt    = 0;
            while (cnt < k[l]) begin
                int p;
                p = $urandom_range(0, n - 1);
                if (!pos[l][p]) begin
                    pos[l][p] = 1'b1;
                    cnt++;
                end
            end
        end
        for (int i = 0; i < n; i++) begin
            logic [LANE_N-1:0] m;
            for (int l = 0; l < LANE_N; l++) m[l] = pos[l][i];
            step('1, mk(m));
        end
    endtask

    initial begin
        logic [LANE_N*HEAD_W-1:0] h;
        nreset      = 1'b1;
        bus.valid_i = '0;
        bus.head_i  = '0;
        #2;
        do_reset();

        // Clean acquisition with alternating headers.
        for (int i = 0; i < SH_CNT_MAX; i++) begin
            step('1, (i % 2 == 0) ? {LANE_N{2'b01}} : {LANE_N{2'b10}});
            if (i == SH_CNT_MAX - 2) chk("lock before 64th", 32'(bus.lock_o), 32'h0);
        end
        chk("lock after 64", 32'(bus.lock_o), 32'hF);
        chk("lock_all after 64", 32'(bus.lock_all_o), 32'h1);

        // Lane 2 bad header during search, ignored headers, fresh acquisition.
        do_reset();
        repeat (30) step('1, mk('0));
        h = mk('0);
        h[5:4] = 2'b11;
        step('1, h);
        chk("lane2 slip pulse", 32'(bus.slip_o), 32'h4);
        repeat (SLIP_WAIT_N) step('1, mk(4'b0100));
        chk("slip single pulse", 32'(bus.slip_o), 32'h0);
        for (int i = 0; i < SH_CNT_MAX; i++) begin
            step('1, mk('0));
            if (i == SH_CNT_MAX - 2) chk("lane2 not yet locked", 32'(bus.lock_o), 32'hB);
        end
        chk("lane2 relocked", 32'(bus.lock_o), 32'hF);

        // 15 bad per window holds lock; 16 in a window drops lanes 1 and 3.
        do_reset();
        acquire();
        window(64, 15, 15, 15, 15);
        chk("15 invalid keeps lock", 32'(bus.lock_o), 32'hF);
        window(64, 15, 16, 15, 16);
        chk("16 invalid drops lock", 32'(bus.lock_o), 32'h5);

        // valid_i toggling during acquisition; unqualified headers are 00.
        do_reset();
        for (int i = 0; i < 2 * SH_CNT_MAX; i++) begin
            if (i % 2 == 1) step('1, mk('0));
            else step('0, '0);
            if (i == 2 * SH_CNT_MAX - 2) chk("toggle lock early", 32'(bus.lock_o), 32'h0);
        end
        chk("toggle lock at 128", 32'(bus.lock_o), 32'hF);

        // Lane 0: 15 bad in first 63, 64th header bad -> loss of lock wins.
        do_reset();
        acquire();
        window(63, 15, 0, 0, 0);
        chk("lane0 still locked", 32'(bus.lock_o), 32'hF);
        step('1, mk(4'b0001));
        chk("window-end invalid lock", 32'(bus.lock_o), 32'hE);
        chk("window-end invalid slip", 32'(bus.slip_o), 32'h1);

        // Random traffic at several error densities.
        do_reset();
        for (int phase = 0; phase < 3; phase++) begin
            int rate;
            rate = (phase == 0) ? 0 : (phase == 1) ? 40 : 6;
            repeat (300) begin
                logic [LANE_N-1:0] v, m;
                for (int l = 0; l < LANE_N; l++) begin
                    v[l] = ($urandom_range(0, 3) != 0);
                    m[l] = (rate != 0) && ($urandom_range(0, rate - 1) == 0);
                end
                step(v, mk(m));
            end
        end

        // Reset while lane 1 is slipping drops the pulse and lock at once.
        do_reset();
        acquire();
        repeat (SH_INVLD_MAX) step('1, mk(4'b0010));
        chk("lane1 slip before reset", 32'(bus.slip_o), 32'h2);
        do_reset();
        acquire();
        chk("lock after reset recovery", 32'(bus.lock_o), 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
